load_store_unit: RTL and testbench

- Sits directly upstream of the memory interface; the CPU datapath issues loads and stores to it.
- Converts RV32I byte, halfword and word accesses into word-aligned 32-bit memory transactions.
- Sub-word stores use read-modify-write. Load data is sign- or zero-extended.
- Stalls the core through a valid/ready handshake.

---
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer in front of a word-wide memory.
// Sub-word stores use read-modify-write; loads are sign/zero extended.
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  if (MEM_RD_LAT != 1) begin : g_lat_check
    $error("load_store_unit supports MEM_RD_LAT == 1 only");
  end

  typedef enum logic [2:0] {IDLE, RD, RD_DATA, WR, RESP} state_t;

  state_t      state, next_state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic        misaligned;
  logic [31:0] merged;
  logic [31:0] extracted;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic        accept;

  assign accept = (state == IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  logic fault_q;

  // Misalignment is judged on the live request so a trap can skip memory entirely.
  always_comb begin
    misaligned = 1'b0;
    if (req_funct3[1:0] == 2'b01)
      misaligned = req_addr[0];
    else if (req_funct3[1])
      misaligned = (req_addr[1:0] != 2'b00);
  end

  // Remember whether the accepted request trapped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fault_q <= 1'b0;
    else if (accept)
      fault_q <= misaligned;
  end

  assign resp_fault = (state == RESP) && fault_q;
`else
  // Without the trap, low address bits beyond the access size are simply ignored.
  assign misaligned = 1'b0;
  assign resp_fault = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic; word stores skip the read, traps skip memory.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned)
            next_state = RESP;
          else if (req_we && req_funct3[1])
            next_state = WR;
          else
            next_state = RD;
        end
      end
      RD:      next_state = RD_DATA;
      RD_DATA: next_state = we_q ? WR : RESP;
      WR:      next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture request fields at acceptance and the read word in RD_DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      word_q   <= '0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        we_q     <= req_we;
        funct3_q <= req_funct3;
      end
      if (state == RD_DATA)
        word_q <= mem_rd;
    end
  end

  // Response data register: loaded on entry to RESP, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata_q <= '0;
    else if (state == RD_DATA && !we_q)
      rdata_q <= extracted;
    else if (state == WR || (accept && misaligned))
      rdata_q <= '0;
  end

  assign byte_sh = mem_rd >> {addr_q[1:0], 3'b000};
  assign half_sh = mem_rd >> {addr_q[1], 4'b0000};

  // Load lane selection and extension from the word arriving in RD_DATA.
  always_comb begin
    extracted = mem_rd;
    unique case (funct3_q)
      3'b000:  extracted = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  extracted = {24'h0, byte_sh[7:0]};
      3'b001:  extracted = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  extracted = {16'h0, half_sh[15:0]};
      default: extracted = mem_rd;
    endcase
  end

  // Store merge of new data into the previously read word.
  always_comb begin
    merged = word_q;
    unique case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Outputs decoded from state so reset clears them immediately.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_rdata = rdata_q;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    if (state == RD || state == RD_DATA || state == WR)
      mem_addr = {addr_q[31:2], 2'b00};
    if (state == WR) begin
      mem_we = 1'b1;
      mem_wd = merged;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a behavioural memory model.
// Honours LSU_MISALIGN_TRAP_EN when defined for the build.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd = '0;

  logic [31:0] tb_mem  [16];
  logic [31:0] ref_mem [16];
  int unsigned wr_count = 0;
  int unsigned resp_count = 0;
  int unsigned txn_count = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  load_store_unit #(.MEM_RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory with one-cycle registered read, plus write/response monitors.
  always @(posedge clk) begin
    mem_rd <= tb_mem[mem_addr[5:2]];
    if (mem_we) begin
      tb_mem[mem_addr[5:2]] <= mem_wd;
      wr_count = wr_count + 1;
      last_wa = mem_addr;
      last_wd = mem_wd;
    end
    if (resp_valid) resp_count = resp_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: RV32I access semantics on a word array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rdata, output logic fault,
                       output int unsigned lat, output int unsigned writes,
                       output logic [31:0] wword);
    int unsigned idx, sz, bo;
    logic [31:0] w, v, mask;
    idx = a[5:2]; sz = f3[1:0]; bo = a[1:0];
    w = ref_mem[idx];
    rdata = '0; fault = 1'b0; writes = 0; wword = w; lat = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((sz == 1 && a[0]) || (sz >= 2 && bo != 0)) begin
      fault = 1'b1; lat = 1;
      return;
    end
`endif
    if (!we) begin
      lat = 3;
      if (sz == 0) begin
        v = (w >> (8 * bo)) & 32'hFF;
        if (f3 == 3'b000 && v >= 128) v = v | 32'hFFFF_FF00;
      end else if (sz == 1) begin
        v = (w >> (16 * (bo / 2))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32768) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      rdata = v;
    end else begin
      writes = 1;
      if (sz == 0) begin
        mask = 32'hFF << (8 * bo);
        wword = (w & ~mask) | ((wd & 32'hFF) << (8 * bo));
        lat = 4;
      end else if (sz == 1) begin
        mask = 32'hFFFF << (16 * (bo / 2));
        wword = (w & ~mask) | ((wd & 32'hFFFF) << (16 * (bo / 2)));
        lat = 4;
      end else begin
        wword = wd;
        lat = 2;
      end
      ref_mem[idx] = wword;
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag, output logic [31:0] got);
    logic [31:0] er, ew;
    logic ef;
    int unsigned el, ewr, lat, wr0, wc;
    model(we, f3, a, wd, er, ef, el, ewr, ew);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    wc = 0;
    while (!req_ready && wc < 20) begin @(negedge clk); wc++; end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    txn_count++;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check({tag, "_latency"}, lat, el);
    check({tag, "_rdata"}, resp_rdata, er);
    check({tag, "_fault"}, 32'(resp_fault), 32'(ef));
    check({tag, "_writes"}, wr_count - wr0, ewr);
    if (ewr != 0) begin
      check({tag, "_waddr"}, last_wa, {a[31:2], 2'b00});
      check({tag, "_wdata"}, last_wd, ew);
    end
    got = resp_rdata;
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    check({tag, "_idle"}, 32'(req_ready), 32'd1);
    check({tag, "_hold"}, resp_rdata, er);
  endtask

  initial begin
    logic [31:0] got, er, ew;
    logic ef;
    int unsigned el, ewr, lat, wr0, wc;
    logic we;
    logic [2:0] f3;

    for (int i = 0; i < 16; i++) begin
      tb_mem[i] = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[0] = 32'h8899_AABB;
    ref_mem[0] = 32'h8899_AABB;

    // Reset state
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_fault", 32'(resp_fault), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed loads and sub-word store
    do_req(1'b0, 3'b000, 32'h0010_0001, 32'h0, "lb", got);
    check("lb_const", got, 32'hFFFF_FFAA);
    do_req(1'b0, 3'b100, 32'h0010_0001, 32'h0, "lbu", got);
    check("lbu_const", got, 32'h0000_00AA);
    do_req(1'b0, 3'b001, 32'h0010_0002, 32'h0, "lh", got);
    check("lh_const", got, 32'hFFFF_8899);
    do_req(1'b0, 3'b101, 32'h0010_0002, 32'h0, "lhu", got);
    check("lhu_const", got, 32'h0000_8899);
    do_req(1'b0, 3'b010, 32'h0010_0000, 32'h0, "lw", got);
    check("lw_const", got, 32'h8899_AABB);
    do_req(1'b1, 3'b000, 32'h0010_0003, 32'h1234_5677, "sb", got);
    check("sb_wdata_const", last_wd, 32'h7799_AABB);
    do_req(1'b0, 3'b010, 32'h0010_0000, 32'h0, "lw_rb", got);
    check("lw_rb_const", got, 32'h7799_AABB);

    // SW followed by a LW held on req_valid while the unit is busy
    model(1'b1, 3'b010, 32'h0010_0004, 32'hDEAD_BEEF, er, ef, el, ewr, ew);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0010_0004; req_wdata = 32'hDEAD_BEEF;
    wr0 = wr_count;
    @(posedge clk); #1;
    txn_count++;
    req_we = 1'b0; req_wdata = '0;
    check("sw_mem_we_k1", 32'(mem_we), 32'd1);
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("sw_latency", lat, 32'd2);
    check("sw_rdata", resp_rdata, 32'd0);
    check("sw_writes", wr_count - wr0, 32'd1);
    check("busy_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("busy_ready_back", 32'(req_ready), 32'd1);
    model(1'b0, 3'b010, 32'h0010_0004, 32'h0, er, ef, el, ewr, ew);
    @(posedge clk); #1;
    req_valid = 1'b0;
    txn_count++;
    check("busy_accepted", 32'(req_ready), 32'd0);
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("busy_lw_latency", lat, 32'd3);
    check("busy_lw_rdata", resp_rdata, 32'hDEAD_BEEF);
    check("busy_lw_model", resp_rdata, er);
    @(posedge clk); #1;

    // Reset during the write cycle of an SH
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h0010_0006; req_wdata = 32'h0000_1234;
    wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wc = 0;
    while (!mem_we && wc < 10) begin @(posedge clk); #1; wc++; end
    check("rst_wr_seen", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    check("rst_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_ready_after", 32'(req_ready), 32'd1);
    check("rst_no_write", wr_count - wr0, 32'd0);
    check("rst_mem_kept", tb_mem[1], ref_mem[1]);

    // Misaligned word load
    do_req(1'b0, 3'b010, 32'h0010_0002, 32'h0, "mis_lw", got);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_lw_const", got, 32'h0);
`else
    check("mis_lw_const", got, 32'h7799_AABB);
`endif

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (we) f3[2] = 1'b0;
      do_req(we, f3, 32'h0010_0000 | 32'($urandom_range(0, 63)), $urandom, "rnd", got);
    end

    for (int i = 0; i < 16; i++) check("final_mem", tb_mem[i], ref_mem[i]);
    check("resp_count", resp_count, txn_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
